// File: rtl/seg_p2s_ctrl.sv
// Shifts a 64-bit segment map MSB-first into chained 74HC595-style registers.
// Completion is 128*HALF cycles after accept; start is ignored while busy.
module seg_p2s_ctrl #(
    parameter int HALF    = 2,
    parameter int REFRESH = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [63:0] seg_map,
    output logic        s_clk,
    output logic        sout,
    output logic        s_clrn,
    output logic        en,
    output logic        busy,
    output logic        done
);

    localparam int PW = (HALF > 1) ? $clog2(HALF) : 1;
    localparam int RW = (REFRESH > 1) ? $clog2(REFRESH) : 1;
    localparam logic [PW-1:0] PLAST = PW'(HALF - 1);
    localparam logic [RW-1:0] RLAST = RW'((REFRESH > 0) ? (REFRESH - 1) : 0);
    localparam bit AUTO = (REFRESH != 0);

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    state_t        state;
    logic [63:0]   shreg;
    logic [5:0]    bcnt;
    logic [PW-1:0] pcnt;
    logic          ph;
    logic [RW-1:0] rcnt;
    logic          refresh_hit;
    logic          trigger;

    // The serial line is the live MSB of the shift register, so it only moves
    // when the register is loaded or shifted (at s_clk falling edges).
    assign sout = shreg[63];

    assign refresh_hit = AUTO && (rcnt == RLAST);
    assign trigger     = start || refresh_hit;

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            shreg  <= '0;
            bcnt   <= '0;
            pcnt   <= '0;
            ph     <= 1'b0;
            rcnt   <= '0;
            s_clk  <= 1'b0;
            s_clrn <= 1'b0;
            en     <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else begin
            s_clrn <= 1'b1;
            done   <= 1'b0;
            case (state)
                IDLE: begin
                    if (trigger) begin
                        shreg <= seg_map;
                        s_clk <= 1'b0;
                        en    <= 1'b0;
                        busy  <= 1'b1;
                        bcnt  <= '0;
                        pcnt  <= '0;
                        ph    <= 1'b0;
                        rcnt  <= '0;
                        state <= SHIFT;
                    end else if (AUTO) begin
                        rcnt <= rcnt + RW'(1);
                    end
                end
                SHIFT: begin
                    if (pcnt != PLAST) begin
                        pcnt <= pcnt + PW'(1);
                    end else begin
                        pcnt <= '0;
                        if (!ph) begin
                            ph    <= 1'b1;
                            s_clk <= 1'b1;
                        end else if (bcnt == 6'd63) begin
                            // Last high phase ends: latch the chain and return to idle.
                            ph    <= 1'b0;
                            s_clk <= 1'b0;
                            en    <= 1'b1;
                            done  <= 1'b1;
                            busy  <= 1'b0;
                            state <= IDLE;
                        end else begin
                            ph    <= 1'b0;
                            s_clk <= 1'b0;
                            shreg <= {shreg[62:0], 1'b0};
                            bcnt  <= bcnt + 6'd1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_seg_p2s_ctrl.sv
// Directed bench for seg_p2s_ctrl: one HALF=2 instance driven by start,
// one HALF=1/REFRESH=20 instance running on auto-refresh alone.
module tb_seg_p2s_ctrl;

    localparam logic [63:0] M1 = 64'hA5_00_FF_01_80_3C_C3_7E;
    localparam logic [63:0] M2 = 64'h0F1E_2D3C_4B5A_6978;
    localparam logic [63:0] M3 = 64'hDEAD_BEEF_0123_4567;
    localparam logic [63:0] MB = 64'h8001_7FFE_5555_AAAA;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [63:0] seg_map;
    logic        s_clk, sout, s_clrn, en, busy, done;

    logic        rst_b;
    logic [63:0] seg_map_b;
    logic        s_clk_b, sout_b, s_clrn_b, en_b, busy_b, done_b;

    int checks = 0;
    int errors = 0;

    int          done_at[$];
    int          acc_at[$];
    logic [63:0] cap[$];
    logic [63:0] word;
    int          rises;
    int          first_rise;
    int          en_busy;
    bit          hold;

    always #5 clk = ~clk;

    seg_p2s_ctrl #(.HALF(2), .REFRESH(0)) u_dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .seg_map (seg_map),
        .s_clk   (s_clk),
        .sout    (sout),
        .s_clrn  (s_clrn),
        .en      (en),
        .busy    (busy),
        .done    (done)
    );

    seg_p2s_ctrl #(.HALF(1), .REFRESH(20)) u_dut_ref (
        .clk     (clk),
        .rst     (rst_b),
        .start   (1'b0),
        .seg_map (seg_map_b),
        .s_clk   (s_clk_b),
        .sout    (sout_b),
        .s_clrn  (s_clrn_b),
        .en      (en_b),
        .busy    (busy_b),
        .done    (done_b)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int int_at(input int q[$], input int idx);
        return (idx < q.size()) ? q[idx] : -1;
    endfunction

    function automatic logic [63:0] word_at(input logic [63:0] q[$], input int idx);
        return (idx < q.size()) ? q[idx] : 64'hx;
    endfunction

    // Drive a one-edge request; returns just after the accepting edge T.
    task automatic kick(input logic [63:0] map);
        seg_map = map;
        start   = 1'b1;
        @(negedge clk);
        start = hold;
    endtask

    // Observe edges T+1..T+n on the HALF=2 instance; pa/pb pulse start.
    task automatic watch(input int n, input int pa, input int pb);
        bit prev_sclk, prev_busy;
        done_at.delete();
        acc_at.delete();
        cap.delete();
        word       = '0;
        rises      = 0;
        first_rise = -1;
        en_busy    = 0;
        prev_sclk  = s_clk;
        prev_busy  = busy;
        for (int i = 1; i <= n; i++) begin
            start = (i == pa || i == pb) ? 1'b1 : hold;
            @(negedge clk);
            if (s_clk && !prev_sclk) begin
                word = {word[62:0], sout};
                rises++;
                if (first_rise < 0) first_rise = i;
            end
            if (busy && !prev_busy) acc_at.push_back(i);
            if (done) begin
                done_at.push_back(i);
                cap.push_back(word);
                word = '0;
            end
            if (en && busy) en_busy++;
            prev_sclk = s_clk;
            prev_busy = busy;
        end
        start = hold;
    endtask

    initial begin
        rst       = 1'b1;
        rst_b     = 1'b1;
        start     = 1'b0;
        hold      = 1'b0;
        seg_map   = '0;
        seg_map_b = MB;

        // Reset held for three edges
        repeat (3) @(negedge clk);
        check("rst_s_clrn", s_clrn, 0);
        check("rst_en", en, 0);
        check("rst_busy", busy, 0);
        check("rst_s_clk", s_clk, 0);
        check("rst_sout", sout, 0);
        check("rst_done", done, 0);
        rst = 1'b0;
        @(negedge clk);
        check("rel_s_clrn", s_clrn, 1);
        check("rel_busy", busy, 0);
        repeat (5) @(negedge clk);
        check("idle_en", en, 0);
        check("idle_busy", busy, 0);

        // Single transfer
        kick(M1);
        check("acc_busy", busy, 1);
        check("acc_sout", sout, M1[63]);
        check("acc_s_clk", s_clk, 0);
        check("acc_en", en, 0);
        watch(300, 0, 0);
        check("x1_done_cnt", done_at.size(), 1);
        check("x1_done_edge", int_at(done_at, 0), 256);
        check("x1_data", word_at(cap, 0), M1);
        check("x1_rises", rises, 64);
        check("x1_first_rise", first_rise, 2);
        check("x1_en_during", en_busy, 0);
        check("x1_en_after", en, 1);
        check("x1_s_clrn", s_clrn, 1);

        // Starts during a transfer are ignored
        kick(M2);
        watch(300, 10, 100);
        check("ign_done_cnt", done_at.size(), 1);
        check("ign_done_edge", int_at(done_at, 0), 256);
        check("ign_reaccept", acc_at.size(), 0);
        check("ign_data", word_at(cap, 0), M2);

        // Back-to-back with start held; seg_map changes mid-shift
        hold = 1'b1;
        kick(M1);
        seg_map = M3;
        watch(513, 0, 0);
        hold  = 1'b0;
        start = 1'b0;
        check("b2b_acc_cnt", acc_at.size(), 1);
        check("b2b_acc_edge", int_at(acc_at, 0), 257);
        check("b2b_done0", int_at(done_at, 0), 256);
        check("b2b_done1", int_at(done_at, 1), 513);
        check("b2b_data0", word_at(cap, 0), M1);
        check("b2b_data1", word_at(cap, 1), M3);

        // Reset at T+50
        kick(M2);
        watch(49, 0, 0);
        rst = 1'b1;
        @(negedge clk);
        check("mid_busy", busy, 0);
        check("mid_s_clk", s_clk, 0);
        check("mid_sout", sout, 0);
        check("mid_en", en, 0);
        check("mid_s_clrn", s_clrn, 0);
        check("mid_done", done, 0);
        rst = 1'b0;
        watch(300, 0, 0);
        check("mid_no_done", done_at.size(), 0);
        check("mid_no_acc", acc_at.size(), 0);
        check("mid_en_low", en, 0);
        kick(M3);
        watch(260, 0, 0);
        check("post_done_edge", int_at(done_at, 0), 256);
        check("post_data", word_at(cap, 0), M3);
        check("post_en", en, 1);

        // Auto-refresh instance
        begin
            int          b_acc[$];
            int          b_done[$];
            logic [63:0] b_word;
            logic [63:0] b_first;
            bit          pb, pc;
            b_word  = '0;
            b_first = 'x;
            rst_b   = 1'b0;
            pb      = busy_b;
            pc      = s_clk_b;
            for (int i = 1; i <= 330; i++) begin
                @(negedge clk);
                if (busy_b && !pb) b_acc.push_back(i);
                if (s_clk_b && !pc) b_word = {b_word[62:0], sout_b};
                if (done_b) begin
                    b_done.push_back(i);
                    if (b_done.size() == 1) b_first = b_word;
                    b_word = '0;
                end
                pb = busy_b;
                pc = s_clk_b;
            end
            check("ref_acc0", int_at(b_acc, 0), 20);
            check("ref_done0", int_at(b_done, 0), 148);
            check("ref_acc1", int_at(b_acc, 1), 168);
            check("ref_done1", int_at(b_done, 1), 296);
            check("ref_acc2", int_at(b_acc, 2), 316);
            check("ref_data", b_first, MB);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
